// File: rtl/tetris_game_sequencer.sv
// Game-level sequencer for the Tetris playfield: spawn -> fall/move -> lock -> clear,
// with gravity derived from the asynchronous arduinoClock timebase, plus score and level.
module tetris_game_sequencer #(
  parameter int GRAVITY_TICKS   = 8,
  parameter int MIN_TICKS       = 1,
  parameter int LINES_PER_LEVEL = 10,
  parameter int SCORE_W         = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               arduinoClock,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               check_req,
  output logic [1:0]         check_op,
  input  logic               check_ack,
  input  logic               check_hit,
  output logic               apply,
  output logic               spawn_req,
  input  logic               spawn_ack,
  input  logic               spawn_hit,
  output logic               lock,
  output logic               clear_req,
  input  logic               clear_done,
  input  logic [2:0]         lines,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               playing,
  output logic               game_over,
  output logic [2:0]         state_dbg_o
);

  // Handshakes: each request (spawn_req, check_req, clear_req) rises on the first cycle
  // of its state and stays high until the matching ack/done is sampled on a clock edge;
  // check_op is stable while check_req is high; an ack/done outside its state is ignored.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    CHECK = 3'd3,
    LOCK  = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6
  } state_t;

  localparam logic [1:0] OP_DOWN = 2'd3;
  localparam int         SW      = SCORE_W + 21;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [2:0]           vld_q;
  logic [7:0]           grav_cnt_q, grav_cnt_d;
  logic                 grav_due_q, grav_due_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [1:0]           buf_cmd_q, buf_cmd_d;
  logic [1:0]           op_q, op_d;
  logic                 apply_q, apply_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           level_q, level_d;
  logic [7:0]           lines_cnt_q, lines_cnt_d;

  logic                 tick;
  logic                 in_play;
  logic [7:0]           thr;
  logic [2:0]           n_sat;
  logic [15:0]          base_pts;
  logic [19:0]          points;
  logic [SW-1:0]        sum_w;
  logic [SCORE_W-1:0]   score_sat;
  logic [7:0]           lines_sum;

  // vld_q marks when prev_q holds a real sample, so a level already high at reset release is not an edge
  assign tick    = vld_q[2] & sync2_q & ~prev_q;
  assign in_play = state_q inside {SPAWN, FALL, CHECK, LOCK, CLEAR};

  always_comb begin
    thr = 8'(GRAVITY_TICKS - int'(level_q));
    if (int'(level_q) >= GRAVITY_TICKS - MIN_TICKS) thr = 8'(MIN_TICKS);
  end

  always_comb begin
    n_sat    = (lines > 3'd4) ? 3'd4 : lines;
    base_pts = 16'd0;
    case (n_sat)
      3'd1:    base_pts = 16'd100;
      3'd2:    base_pts = 16'd300;
      3'd3:    base_pts = 16'd500;
      3'd4:    base_pts = 16'd800;
      default: base_pts = 16'd0;
    endcase
    points    = 20'(base_pts) * (20'(level_q) + 20'd1);
    sum_w     = SW'(score_q) + SW'(points);
    score_sat = sum_w[SCORE_W-1:0];
    if (sum_w > SW'({SCORE_W{1'b1}})) score_sat = {SCORE_W{1'b1}};
    lines_sum = lines_cnt_q + 8'(n_sat);
  end

  always_comb begin
    state_d     = state_q;
    grav_cnt_d  = grav_cnt_q;
    grav_due_d  = grav_due_q;
    buf_valid_d = buf_valid_q;
    buf_cmd_d   = buf_cmd_q;
    op_d        = op_q;
    apply_d     = 1'b0;
    score_d     = score_q;
    level_d     = level_q;
    lines_cnt_d = lines_cnt_q;

    if ((state_q == FALL || state_q == CHECK) && tick) begin
      if (grav_cnt_q + 8'd1 >= thr) begin
        grav_due_d = 1'b1;
        grav_cnt_d = 8'd0;
      end else begin
        grav_cnt_d = grav_cnt_q + 8'd1;
      end
    end

    if (in_play && cmd_valid && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_cmd_d   = cmd;
    end

    case (state_q)
      IDLE: if (start) state_d = SPAWN;
      SPAWN: begin
        if (spawn_ack) begin
          if (spawn_hit) begin
            state_d = OVER;
          end else begin
            state_d    = FALL;
            grav_cnt_d = 8'd0;
            grav_due_d = 1'b0;
          end
        end
      end
      FALL: begin
        if (grav_due_q) begin
          op_d    = OP_DOWN;
          state_d = CHECK;
        end else if (buf_valid_q) begin
          op_d        = buf_cmd_q;
          buf_valid_d = 1'b0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (check_ack) begin
          if (!check_hit) begin
            apply_d = 1'b1;
            state_d = FALL;
            if (op_q == OP_DOWN) begin
              grav_cnt_d = 8'd0;
              grav_due_d = 1'b0;
            end
          end else if (op_q == OP_DOWN) begin
            state_d = LOCK;
          end else begin
            state_d = FALL;
          end
        end
      end
      LOCK: state_d = CLEAR;
      CLEAR: begin
        if (clear_done) begin
          score_d     = score_sat;
          lines_cnt_d = lines_sum;
          if (lines_sum >= 8'(LINES_PER_LEVEL)) begin
            lines_cnt_d = lines_sum - 8'(LINES_PER_LEVEL);
            if (level_q != 4'd15) level_d = level_q + 4'd1;
          end
          state_d = SPAWN;
        end
      end
      OVER: begin
        if (start) begin
          score_d     = '0;
          level_d     = 4'd0;
          lines_cnt_d = 8'd0;
          state_d     = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == SPAWN && state_q != SPAWN) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      vld_q       <= 3'b000;
      grav_cnt_q  <= 8'd0;
      grav_due_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_cmd_q   <= 2'd0;
      op_q        <= 2'd0;
      apply_q     <= 1'b0;
      score_q     <= '0;
      level_q     <= 4'd0;
      lines_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= arduinoClock;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      vld_q       <= {vld_q[1:0], 1'b1};
      grav_cnt_q  <= grav_cnt_d;
      grav_due_q  <= grav_due_d;
      buf_valid_q <= buf_valid_d;
      buf_cmd_q   <= buf_cmd_d;
      op_q        <= op_d;
      apply_q     <= apply_d;
      score_q     <= score_d;
      level_q     <= level_d;
      lines_cnt_q <= lines_cnt_d;
    end
  end

  assign check_req   = (state_q == CHECK);
  assign check_op    = op_q;
  assign apply       = apply_q;
  assign spawn_req   = (state_q == SPAWN);
  assign lock        = (state_q == LOCK);
  assign clear_req   = (state_q == CLEAR);
  assign score       = score_q;
  assign level       = level_q;
  assign playing     = in_play;
  assign game_over   = (state_q == OVER);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Self-checking bench for tetris_game_sequencer: directed lifecycle sequences, a scoring
// vector table and a randomized game checked against an arithmetic score/level model.
module tb_tetris_game_sequencer;

  localparam int         SCORE_W  = 16;
  localparam int         SCORE_MAX = 65535;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FALL  = 3'd2;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic               arduinoClock = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd = 2'd0;
  logic               check_req;
  logic [1:0]         check_op;
  logic               check_ack = 1'b0;
  logic               check_hit = 1'b0;
  logic               apply;
  logic               spawn_req;
  logic               spawn_ack = 1'b0;
  logic               spawn_hit = 1'b0;
  logic               lock;
  logic               clear_req;
  logic               clear_done = 1'b0;
  logic [2:0]         lines = 3'd0;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;
  logic               playing;
  logic               game_over;
  logic [2:0]         state_dbg;

  tetris_game_sequencer #(
    .GRAVITY_TICKS(8), .MIN_TICKS(1), .LINES_PER_LEVEL(10), .SCORE_W(SCORE_W)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .arduinoClock(arduinoClock),
    .cmd_valid(cmd_valid), .cmd(cmd), .check_req(check_req), .check_op(check_op),
    .check_ack(check_ack), .check_hit(check_hit), .apply(apply), .spawn_req(spawn_req),
    .spawn_ack(spawn_ack), .spawn_hit(spawn_hit), .lock(lock), .clear_req(clear_req),
    .clear_done(clear_done), .lines(lines), .score(score), .level(level),
    .playing(playing), .game_over(game_over), .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  int         apply_cnt = 0;
  int         op_changes = 0;
  logic       prev_req = 1'b0;
  logic [1:0] prev_op = 2'd0;
  int         m_score = 0;
  int         m_level = 0;
  int         m_lines = 0;

  always @(negedge clock) begin
    if (apply === 1'b1) apply_cnt <= apply_cnt + 1;
    if (check_req === 1'b1 && prev_req && check_op !== prev_op) op_changes <= op_changes + 1;
    prev_req <= check_req;
    prev_op  <= check_op;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference model: scoring rules written directly as arithmetic
  function automatic int points_for(input int n, input int lvl);
    int tbl_pts[5] = '{0, 100, 300, 500, 800};
    int k = (n > 4) ? 4 : n;
    return tbl_pts[k] * (lvl + 1);
  endfunction

  task automatic model_clear(input int n);
    int k = (n > 4) ? 4 : n;
    m_score += points_for(n, m_level);
    if (m_score > SCORE_MAX) m_score = SCORE_MAX;
    m_lines += k;
    if (m_lines >= 10) begin
      m_lines -= 10;
      if (m_level < 15) m_level++;
    end
  endtask

  function automatic int model_thr();
    return (8 - m_level < 1) ? 1 : 8 - m_level;
  endfunction

  // driver tasks
  function automatic logic sig(input int s);
    case (s)
      0:       return spawn_req;
      1:       return check_req;
      2:       return clear_req;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int s, input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sig(s) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) check(name, 0, 1);
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic do_spawn(input bit hit);
    bit ok;
    wait_sig(0, 20, "spawn_req_timeout", ok);
    if (!ok) return;
    spawn_ack = 1'b1;
    spawn_hit = hit;
    @(negedge clock);
    spawn_ack = 1'b0;
    spawn_hit = 1'b0;
  endtask

  task automatic expect_check(input bit hit, input int budget);
    bit ok;
    logic [1:0] e;
    wait_sig(1, budget, "check_req_timeout", ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      check("unexpected_check", 1, 0);
      e = 2'd0;
    end else begin
      e = exp_q.pop_front();
    end
    check("check_op", 32'(check_op), 32'(e));
    repeat ($urandom_range(0, 2)) @(negedge clock);
    check_ack = 1'b1;
    check_hit = hit;
    @(negedge clock);
    check_ack = 1'b0;
    check_hit = 1'b0;
    check("apply_after_ack", 32'(apply), hit ? 0 : 1);
    if (!hit) begin
      @(negedge clock);
      check("apply_one_cycle", 32'(apply), 0);
    end
  endtask

  task automatic do_clear(input logic [2:0] n);
    bit ok;
    wait_sig(2, 20, "clear_req_timeout", ok);
    if (!ok) return;
    clear_done = 1'b1;
    lines = n;
    @(negedge clock);
    clear_done = 1'b0;
    lines = 3'd0;
  endtask

  // from FALL: soft-down that collides, lock pulse, then line clear of n rows
  task automatic run_piece(input logic [2:0] n);
    exp_q.push_back(2'd3);
    send_cmd(2'd3);
    expect_check(1'b1, 10);
    check("lock_pulse", 32'(lock), 1);
    @(negedge clock);
    check("lock_one_cycle", 32'(lock), 0);
    check("clear_req_after_lock", 32'(clear_req), 1);
    do_clear(n);
  endtask

  task automatic grav_edge();
    arduinoClock = 1'b1;
    repeat (4) @(negedge clock);
    arduinoClock = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic grav_quiet(input int n, input string name);
    repeat (n) grav_edge();
    check(name, 32'(check_req), 0);
  endtask

  // the next edge must raise a down check within 4 clocks
  task automatic grav_fire(input bit hit);
    arduinoClock = 1'b1;
    exp_q.push_back(2'd3);
    expect_check(hit, 5);
    arduinoClock = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  typedef struct {
    logic [2:0] n;
    int         exp_score;
    int         exp_level;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int a0;
    bit ok;

    tbl[0] = '{3'd4,  800, 0};
    tbl[1] = '{3'd4, 1600, 0};
    tbl[2] = '{3'd2, 1900, 1};
    tbl[3] = '{3'd1, 2100, 1};
    tbl[4] = '{3'd7, 3700, 1};
    tbl[5] = '{3'd0, 3700, 1};
    tbl[6] = '{3'd3, 4700, 1};
    tbl[7] = '{3'd3, 5700, 2};

    // reset state
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_check_req", 32'(check_req), 0);
    check("rst_check_op", 32'(check_op), 0);
    check("rst_spawn_req", 32'(spawn_req), 0);
    check("rst_apply", 32'(apply), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_clear_req", 32'(clear_req), 0);
    check("rst_score", 32'(score), 0);
    check("rst_level", 32'(level), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_holds_without_start", 32'(state_dbg), 32'(ST_IDLE));

    // start and spawn
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("spawn_req_after_start", 32'(spawn_req), 1);
    check("playing_in_spawn", 32'(playing), 1);
    repeat (2) @(negedge clock);
    check("spawn_req_held", 32'(spawn_req), 1);
    do_spawn(1'b0);
    check("state_fall", 32'(state_dbg), 32'(ST_FALL));
    check("score_zero", 32'(score), 0);
    check("level_zero", 32'(level), 0);

    // gravity at level 0: threshold 8
    grav_quiet(7, "no_check_7_edges");
    grav_fire(1'b0);
    grav_quiet(7, "no_check_after_apply");
    grav_fire(1'b0);

    // command buffer: one pending, second dropped
    exp_q.push_back(2'd1);
    send_cmd(2'd1);
    wait_sig(1, 10, "cmd_check_timeout", ok);
    if (ok) begin
      check("check_op_right", 32'(check_op), 32'(exp_q.pop_front()));
      send_cmd(2'd0);
      send_cmd(2'd2);
      check("check_req_still_pending", 32'(check_req), 1);
      check_ack = 1'b1;
      check_hit = 1'b1;
      @(negedge clock);
      check_ack = 1'b0;
      check_hit = 1'b0;
      check("no_apply_on_side_hit", 32'(apply), 0);
      exp_q.push_back(2'd0);
      expect_check(1'b0, 10);
      repeat (10) @(negedge clock);
      check("rotate_dropped", 32'(check_req), 0);
    end

    // start pulse ignored while playing
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("start_ignored_in_fall", 32'(state_dbg), 32'(ST_FALL));

    // scoring table
    for (int i = 0; i < 8; i++) begin
      run_piece(tbl[i].n);
      model_clear(int'(tbl[i].n));
      check($sformatf("tbl%0d_score", i), 32'(score), 32'(tbl[i].exp_score));
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      do_spawn(1'b0);
    end

    // level 2 shortens gravity to 6 ticks
    grav_quiet(5, "no_check_thr6");
    grav_fire(1'b0);

    // randomized play against the model
    for (int p = 0; p < 40; p++) begin
      int k = $urandom_range(0, 2);
      int n;
      for (int j = 0; j < k; j++) begin
        logic [1:0] op = 2'($urandom_range(0, 2));
        exp_q.push_back(op);
        send_cmd(op);
        expect_check(1'($urandom_range(0, 1)), 10);
      end
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 4;
      run_piece(3'(n));
      model_clear(n);
      check($sformatf("rnd%0d_score", p), 32'(score), 32'(m_score));
      check($sformatf("rnd%0d_level", p), 32'(level), 32'(m_level));
      do_spawn(1'b0);
    end

    // gravity threshold at the model's current level (floors at 1)
    grav_quiet(model_thr() - 1, "no_check_before_thr");
    grav_fire(1'b0);

    // game over and restart
    run_piece(3'd1);
    model_clear(1);
    do_spawn(1'b1);
    check("game_over_set", 32'(game_over), 1);
    check("playing_clear_in_over", 32'(playing), 0);
    check("spawn_req_clear_in_over", 32'(spawn_req), 0);
    repeat (3) @(negedge clock);
    check("score_holds_in_over", 32'(score), 32'(m_score));
    check("level_holds_in_over", 32'(level), 32'(m_level));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_score = 0;
    m_level = 0;
    m_lines = 0;
    check("restart_score", 32'(score), 0);
    check("restart_level", 32'(level), 0);
    check("restart_spawn_req", 32'(spawn_req), 1);
    check("restart_game_over", 32'(game_over), 0);
    do_spawn(1'b0);

    // lines counter restarted: 9 lines stay at level 0, the 10th advances
    for (int i = 0; i < 4; i++) begin
      int n = (i < 2) ? 4 : 1;
      run_piece(3'(n));
      model_clear(n);
      check($sformatf("relevel%0d_score", i), 32'(score), 32'(m_score));
      check($sformatf("relevel%0d_level", i), 32'(level), 32'(m_level));
      do_spawn(1'b0);
    end

    // reset in the middle of a check handshake
    exp_q.push_back(2'd0);
    send_cmd(2'd0);
    wait_sig(1, 10, "pre_reset_check_timeout", ok);
    if (ok) check("pre_reset_op", 32'(check_op), 32'(exp_q.pop_front()));
    resetn = 1'b0;
    @(negedge clock);
    check("reset_drops_check_req", 32'(check_req), 0);
    check("reset_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("reset_score", 32'(score), 0);
    check("reset_level", 32'(level), 0);
    check("reset_playing", 32'(playing), 0);
    resetn = 1'b1;
    exp_q.delete();
    a0 = apply_cnt;
    check_ack = 1'b1;
    @(negedge clock);
    check_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("late_ack_no_apply", 32'(apply_cnt - a0), 0);
    check("late_ack_stays_idle", 32'(state_dbg), 32'(ST_IDLE));

    // final report
    check("check_op_stable", 32'(op_changes), 0);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
